// File: rtl/adff_write_arbiter_if.sv
// Request/response bundle between the requesters and the shared-register write arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until gnt and ack; lock extends ownership for streaming writes.
interface adff_write_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 2
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] d;
   logic [NREQ-1:0]       lock;
   logic [NREQ-1:0]       gnt;
   logic                  ack;
   logic [WIDTH-1:0]      q;
   logic [OW-1:0]         owner;
   logic                  busy;

   // Requester side drives requests and data, observes the arbiter outputs.
   modport master (
      output req, d, lock,
      input  gnt, ack, q, owner, busy
   );

   // Arbiter side.
   modport slave (
      input  req, d, lock,
      output gnt, ack, q, owner, busy
   );
endinterface

// File: rtl/adff_write_arbiter.sv
// Round-robin arbiter giving NREQ requesters write access to one shared WIDTH-bit register.
// Latency: grant one edge after a request in IDLE; write and ack on the following edge.
// Backpressure: non-owners wait until the next IDLE cycle; the owner may withdraw or hold via lock.
module adff_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 2
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   adff_write_arbiter_if.slave  bus_if
);
   localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IDXW = OW + 1;
   localparam logic [IDXW-1:0] NREQ_C = IDXW'(NREQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ack_q, ack_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q, ptr_d;

   logic [OW-1:0]    winner;
   logic             found;
   logic [IDXW-1:0]  idx;
   logic [OW-1:0]    owner_inc;
   logic             own_req;
   logic             own_lock;
   logic [WIDTH-1:0] own_dat;

   // Owner's request, lock and data slot; only the owner is looked at outside IDLE.
   assign own_req   = bus_if.req[owner_q];
   assign own_lock  = bus_if.lock[owner_q];
   assign own_dat   = bus_if.d[owner_q*WIDTH +: WIDTH];
   assign owner_inc = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

   // Round-robin search: first active request starting at ptr, wrapping modulo NREQ.
   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr_q} + IDXW'(i);
         if (idx >= NREQ_C) begin
            idx = idx - NREQ_C;
         end
         if (!found && bus_if.req[idx[OW-1:0]]) begin
            winner = idx[OW-1:0];
            found  = 1'b1;
         end
      end
   end

   // Next-state logic: grant in IDLE, write in GRANT/HOLD, pointer advances only after a write.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      ack_d   = 1'b0;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|bus_if.req) begin
               state_d = GRANT;
               owner_d = winner;
            end
         end
         GRANT: begin
            if (own_req) begin
               q_d   = own_dat;
               ack_d = 1'b1;
               if (own_lock) begin
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
                  ptr_d   = owner_inc;
               end
            end else begin
               // Withdrawal: nothing written, so the pointer stays put.
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (own_req && own_lock) begin
               q_d   = own_dat;
               ack_d = 1'b1;
            end else begin
               // HOLD is only reached after a write, so the pointer always advances here.
               state_d = IDLE;
               ptr_d   = owner_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared immediately by the asynchronous reset.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         q_q     <= '0;
         ack_q   <= 1'b0;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         ack_q   <= ack_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   // One-hot grant decoded from registered state and owner, zero in IDLE.
   always_comb begin
      bus_if.gnt = '0;
      if (state_q != IDLE) begin
         bus_if.gnt[owner_q] = 1'b1;
      end
   end

   assign bus_if.busy  = (state_q != IDLE);
   assign bus_if.ack   = ack_q;
   assign bus_if.q     = q_q;
   assign bus_if.owner = owner_q;

endmodule

// File: tb/tb_adff_write_arbiter.sv
// Self-checking bench for adff_write_arbiter: vector table, directed corner sequences, random vs model.
// Latency: inputs applied after an edge, outputs sampled 1 ns after the next edge.
// Backpressure: none; the bench drives every cycle and never waits on the DUT.
module tb_adff_write_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 2;

   logic clk_i   = 1'b0;
   logic arst_ni = 1'b1;

   adff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   adff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .bus_if  (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model: who holds the register, whether they have written yet, and the pointer.
   bit       m_active;
   bit       m_written;
   int       m_owner;
   int       m_ptr;
   int       m_q;
   bit       m_ack;

   typedef struct {
      logic [3:0] req;
      logic [3:0] lock;
      logic [7:0] d;
      logic [3:0] gnt;
      logic       ack;
      logic [1:0] q;
      logic [1:0] owner;
      logic       busy;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active  = 1'b0;
      m_written = 1'b0;
      m_owner   = 0;
      m_ptr     = 0;
      m_q       = 0;
      m_ack     = 1'b0;
   endtask

   // Applies the arbitration rules to the inputs present at the edge just taken.
   task automatic model_edge();
      logic [3:0] r;
      logic [3:0] l;
      logic [7:0] dd;
      r  = bus.req;
      l  = bus.lock;
      dd = bus.d;
      if (!m_active) begin
         m_ack = 1'b0;
         if (r != 0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
               int c;
               c = (m_ptr + k) % NREQ;
               if (r[c]) m_owner = c;
            end
            m_active  = 1'b1;
            m_written = 1'b0;
         end
      end else if (r[m_owner] && (!m_written || l[m_owner])) begin
         m_q       = int'(dd[m_owner*WIDTH +: WIDTH]);
         m_ack     = 1'b1;
         m_written = 1'b1;
         if (!l[m_owner]) begin
            m_active = 1'b0;
            m_ptr    = (m_owner + 1) % NREQ;
         end
      end else begin
         m_ack    = 1'b0;
         m_active = 1'b0;
         if (m_written) m_ptr = (m_owner + 1) % NREQ;
      end
   endtask

   task automatic check_model(input string tag);
      int exp_gnt;
      exp_gnt = m_active ? (1 << m_owner) : 0;
      chk({tag, ".gnt"},   int'(bus.gnt),   exp_gnt);
      chk({tag, ".ack"},   int'(bus.ack),   int'(m_ack));
      chk({tag, ".q"},     int'(bus.q),     m_q);
      chk({tag, ".owner"}, int'(bus.owner), m_owner);
      chk({tag, ".busy"},  int'(bus.busy),  int'(m_active));
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   initial begin
      // Round robin with REQ=1111 (slots 3..0 = 11,10,01,00), then a single request from 0 with slot0=10.
      vecs[0]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0001, 1'b0, 2'b00, 2'd0, 1'b1};
      vecs[1]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0000, 1'b1, 2'b00, 2'd0, 1'b0};
      vecs[2]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0010, 1'b0, 2'b00, 2'd1, 1'b1};
      vecs[3]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0000, 1'b1, 2'b01, 2'd1, 1'b0};
      vecs[4]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0100, 1'b0, 2'b01, 2'd2, 1'b1};
      vecs[5]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0000, 1'b1, 2'b10, 2'd2, 1'b0};
      vecs[6]  = '{4'b1111, 4'b0000, 8'hE4, 4'b1000, 1'b0, 2'b10, 2'd3, 1'b1};
      vecs[7]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0000, 1'b1, 2'b11, 2'd3, 1'b0};
      vecs[8]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0001, 1'b0, 2'b11, 2'd0, 1'b1};
      vecs[9]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0000, 1'b1, 2'b00, 2'd0, 1'b0};
      vecs[10] = '{4'b0001, 4'b0000, 8'h02, 4'b0001, 1'b0, 2'b00, 2'd0, 1'b1};
      vecs[11] = '{4'b0001, 4'b0000, 8'h02, 4'b0000, 1'b1, 2'b10, 2'd0, 1'b0};
      vecs[12] = '{4'b0000, 4'b0000, 8'h02, 4'b0000, 1'b0, 2'b10, 2'd0, 1'b0};

      bus.req  = '0;
      bus.lock = '0;
      bus.d    = '0;
      model_reset();

      // Reset values, checked before any clock edge.
      #1 arst_ni = 1'b0;
      #1;
      chk("rst.q",     int'(bus.q),     0);
      chk("rst.gnt",   int'(bus.gnt),   0);
      chk("rst.ack",   int'(bus.ack),   0);
      chk("rst.owner", int'(bus.owner), 0);
      chk("rst.busy",  int'(bus.busy),  0);
      #6 arst_ni = 1'b1;

      // Vector table.
      for (int i = 0; i < 13; i++) begin
         bus.req  = vecs[i].req;
         bus.lock = vecs[i].lock;
         bus.d    = vecs[i].d;
         tick();
         chk($sformatf("vec%0d.gnt", i),   int'(bus.gnt),   int'(vecs[i].gnt));
         chk($sformatf("vec%0d.ack", i),   int'(bus.ack),   int'(vecs[i].ack));
         chk($sformatf("vec%0d.q", i),     int'(bus.q),     int'(vecs[i].q));
         chk($sformatf("vec%0d.owner", i), int'(bus.owner), int'(vecs[i].owner));
         chk($sformatf("vec%0d.busy", i),  int'(bus.busy),  int'(vecs[i].busy));
      end

      // Locked stream from requester 2, then hand-off to requester 3.
      bus.req  = 4'b0100;
      bus.lock = 4'b0100;
      bus.d    = 8'h00;
      tick();
      chk("lock.grant", int'(bus.gnt), 4'b0100);
      for (int s = 0; s < 4; s++) begin
         bus.d = 8'(s << 4);
         tick();
         chk($sformatf("lock.q%0d", s),   int'(bus.q),   s);
         chk($sformatf("lock.ack%0d", s), int'(bus.ack), 1);
         check_model("lock");
      end
      bus.lock = 4'b0000;
      bus.req  = 4'b1100;
      tick();
      chk("lock.drop_ack",  int'(bus.ack),  0);
      chk("lock.drop_busy", int'(bus.busy), 0);
      chk("lock.drop_q",    int'(bus.q),    3);
      tick();
      chk("lock.next_gnt",   int'(bus.gnt),   4'b1000);
      chk("lock.next_owner", int'(bus.owner), 3);
      bus.d = 8'b01_00_00_00;
      tick();
      chk("lock.w3_q", int'(bus.q), 1);
      check_model("lock");

      // Withdrawal by requester 1 leaves Q and the pointer untouched.
      bus.req = 4'b0001;
      bus.d   = 8'h0E;
      tick();
      tick();
      chk("wd.pre_q", int'(bus.q), 2);
      bus.req = 4'b0010;
      tick();
      chk("wd.gnt", int'(bus.gnt), 4'b0010);
      bus.req = 4'b0000;
      tick();
      chk("wd.ack",  int'(bus.ack),  0);
      chk("wd.q",    int'(bus.q),    2);
      chk("wd.busy", int'(bus.busy), 0);
      bus.req = 4'b0110;
      tick();
      chk("wd.regrant_gnt",   int'(bus.gnt),   4'b0010);
      chk("wd.regrant_owner", int'(bus.owner), 1);
      tick();
      chk("wd.write_q", int'(bus.q), 3);
      check_model("wd");
      bus.req = 4'b0000;
      tick();

      // Reset pulse while streaming in HOLD with Q=11.
      bus.req  = 4'b0001;
      bus.lock = 4'b0001;
      bus.d    = 8'h03;
      tick();
      tick();
      chk("rh.q_before", int'(bus.q),    3);
      chk("rh.busy",     int'(bus.busy), 1);
      #1 arst_ni = 1'b0;
      #2;
      chk("rh.q",    int'(bus.q),    0);
      chk("rh.gnt",  int'(bus.gnt),  0);
      chk("rh.ack",  int'(bus.ack),  0);
      chk("rh.busy", int'(bus.busy), 0);
      model_reset();
      #3 arst_ni = 1'b1;
      bus.req  = 4'b1111;
      bus.lock = 4'b0000;
      tick();
      chk("rh.first_gnt",   int'(bus.gnt),   4'b0001);
      chk("rh.first_owner", int'(bus.owner), 0);
      check_model("rh");

      // Random traffic against the model, with occasional mid-cycle resets.
      for (int n = 0; n < 3000; n++) begin
         bus.req  = 4'($urandom_range(0, 15));
         bus.lock = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         bus.d    = 8'($urandom);
         tick();
         check_model("rnd");
         if ($urandom_range(0, 199) == 0) begin
            #2 arst_ni = 1'b0;
            #1;
            chk("rnd.rst_busy", int'(bus.busy), 0);
            chk("rnd.rst_q",    int'(bus.q),    0);
            model_reset();
            #2 arst_ni = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
